// File: rtl/fourfunc_issue_ctrl_if.sv
// Bundle of request, fourFunc-side and result handshake signals for fourfunc_issue_ctrl.
// master is the controller's view, slave is the environment's (requester, fourFunc, consumer).
interface fourfunc_issue_ctrl_if #(
  parameter int IPART_W = 8,
  parameter int FPART_W = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         in_func;
  logic [7:0]         in_x;
  logic               start;
  logic [1:0]         func;
  logic [7:0]         x;
  logic               busy;
  logic [IPART_W-1:0] resultIPart;
  logic [FPART_W-1:0] resultFPart;
  logic               out_valid;
  logic               out_ready;
  logic [1:0]         out_func;
  logic [IPART_W-1:0] out_ipart;
  logic [FPART_W-1:0] out_fpart;
  logic               err_timeout;

  modport master (
    input  in_valid, in_func, in_x, busy, resultIPart, resultFPart, out_ready,
    output in_ready, start, func, x, out_valid, out_func, out_ipart, out_fpart, err_timeout
  );
  modport slave (
    output in_valid, in_func, in_x, busy, resultIPart, resultFPart, out_ready,
    input  in_ready, start, func, x, out_valid, out_func, out_ipart, out_fpart, err_timeout
  );
endinterface

// File: rtl/fourfunc_issue_ctrl.sv
// Request FIFO plus start/busy sequencer for the fourFunc unit; results land in a
// valid/ready output register. err_timeout latches when busy never answers a start.
module fourfunc_issue_ctrl #(
  parameter int DEPTH        = 4,
  parameter int IPART_W      = 8,
  parameter int FPART_W      = 8,
  parameter int BUSY_TIMEOUT = 15
) (
  input logic                   clk,
  input logic                   rst,
  fourfunc_issue_ctrl_if.master bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ISSUE   = 3'd1;
  localparam logic [2:0] S_WAIT_HI = 3'd2;
  localparam logic [2:0] S_RUN     = 3'd3;
  localparam logic [2:0] S_HOLD    = 3'd4;

  typedef struct packed {
    logic [1:0] func;
    logic [7:0] x;
  } req_t;

  req_t [DEPTH-1:0]   mem_q, mem_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         state_q, state_d;
  logic [1:0]         func_q, func_d;
  logic [7:0]         x_q, x_d;
  logic [TW-1:0]      tmo_q, tmo_d, tmo_inc;
  logic               out_valid_q, out_valid_d;
  logic [1:0]         out_func_q, out_func_d;
  logic [IPART_W-1:0] ipart_q, ipart_d;
  logic [FPART_W-1:0] fpart_q, fpart_d;
  logic               err_q, err_d;

  logic full, empty, in_ready, push, pop;

  assign full     = (cnt_q == CW'(DEPTH));
  assign empty    = (cnt_q == '0);
  // Held low during reset so nothing is accepted while the block is being cleared.
  assign in_ready = !full && !rst;
  assign push     = bus.in_valid && in_ready;
  assign pop      = (state_q == S_IDLE) && !empty;
  assign tmo_inc  = tmo_q + 1'b1;

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    state_d     = state_q;
    func_d      = func_q;
    x_d         = x_q;
    tmo_d       = tmo_q;
    out_valid_d = out_valid_q;
    out_func_d  = out_func_q;
    ipart_d     = ipart_q;
    fpart_d     = fpart_q;
    err_d       = err_q;

    if (push) begin
      mem_d[wr_ptr_q] = '{func: bus.in_func, x: bus.in_x};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          func_d  = mem_q[rd_ptr_q].func;
          x_d     = mem_q[rd_ptr_q].x;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        tmo_d   = '0;
        state_d = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        // The timeout wins over a busy that rises on the very cycle the count expires.
        if (tmo_inc == TW'(BUSY_TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else if (bus.busy) begin
          state_d = S_RUN;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      S_RUN: begin
        if (!bus.busy) begin
          out_func_d  = func_q;
          ipart_d     = bus.resultIPart;
          fpart_d     = bus.resultFPart;
          out_valid_d = 1'b1;
          state_d     = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) mem_q <= mem_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      state_q     <= S_IDLE;
      func_q      <= '0;
      x_q         <= '0;
      tmo_q       <= '0;
      out_valid_q <= 1'b0;
      out_func_q  <= '0;
      ipart_q     <= '0;
      fpart_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      func_q      <= func_d;
      x_q         <= x_d;
      tmo_q       <= tmo_d;
      out_valid_q <= out_valid_d;
      out_func_q  <= out_func_d;
      ipart_q     <= ipart_d;
      fpart_q     <= fpart_d;
      err_q       <= err_d;
    end
  end

  assign bus.in_ready    = in_ready;
  assign bus.start       = (state_q == S_ISSUE);
  assign bus.func        = func_q;
  assign bus.x           = x_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_func    = out_func_q;
  assign bus.out_ipart   = ipart_q;
  assign bus.out_fpart   = fpart_q;
  assign bus.err_timeout = err_q;
endmodule

// File: tb/tb_fourfunc_issue_ctrl.sv
// Bench for fourfunc_issue_ctrl: a fourFunc responder model, a queue-based scoreboard,
// a latency vector table and directed multi-cycle sequences.
module tb_fourfunc_issue_ctrl;
  localparam int DEPTH = 4;
  localparam int IW    = 8;
  localparam int FW    = 8;
  localparam int TMO   = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fourfunc_issue_ctrl_if #(.IPART_W(IW), .FPART_W(FW)) bus ();
  fourfunc_issue_ctrl #(.DEPTH(DEPTH), .IPART_W(IW), .FPART_W(FW), .BUSY_TIMEOUT(TMO))
    dut (.clk(clk), .rst(rst), .bus(bus));

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, want, $time);
  endtask

  // fourFunc responder: busy rises r_dly cycles after start, stays r_len cycles.
  int         r_dly = 2, r_len = 6;
  logic [7:0] r_ip = 8'h0, r_fp = 8'h0;
  bit         r_never = 1'b0, r_rand = 1'b0;
  int         dly_c = 0, len_c = 0, n_starts = 0;

  typedef struct { logic [1:0] f; logic [7:0] x; } req_s;
  typedef struct { logic [1:0] f; logic [7:0] ip; logic [7:0] fp; } res_s;
  req_s req_q[$];
  res_s exp_q[$];
  req_s cur;
  int   n_res = 0;

  logic       d_valid = 1'b0, d_ordy = 1'b0;
  logic [1:0] d_func = 2'd0;
  logic [7:0] d_x = 8'h0;
  bit         last_acc = 1'b0;

  task automatic resp_step();
    if (rst) begin
      bus.busy = 1'b0; dly_c = 0; len_c = 0;
      return;
    end
    if (bus.start) begin
      n_starts++;
      if (r_rand) begin
        r_dly = $urandom_range(1, 4);
        r_len = $urandom_range(1, 5);
        r_ip  = 8'($urandom);
        r_fp  = 8'($urandom);
      end
      dly_c = r_never ? 0 : r_dly;
    end else if (dly_c > 0) begin
      dly_c--;
      if (dly_c == 0) begin
        bus.busy = 1'b1; len_c = r_len;
        bus.resultIPart = ~r_ip; bus.resultFPart = ~r_fp;
      end
    end else if (len_c > 0) begin
      len_c--;
      if (len_c == 0) begin
        bus.busy = 1'b0;
        bus.resultIPart = r_ip; bus.resultFPart = r_fp;
      end
    end
  endtask

  task automatic tick();
    @(negedge clk);
    resp_step();
  endtask

  // One scoreboarded cycle: check what the last edge produced, then drive the next inputs.
  task automatic step();
    tick();
    if (bus.start) begin
      chk("start_queued", 32'(req_q.size() != 0), 1);
      if (req_q.size() != 0) begin
        cur = req_q.pop_front();
        chk("start_func", 32'(bus.func), 32'(cur.f));
        chk("start_x", 32'(bus.x), 32'(cur.x));
        if (!r_never) exp_q.push_back(res_s'{cur.f, r_ip, r_fp});
      end
    end
    if (bus.busy) begin
      chk("busy_func_hold", 32'(bus.func), 32'(cur.f));
      chk("busy_x_hold", 32'(bus.x), 32'(cur.x));
    end
    chk("in_ready", 32'(bus.in_ready), 32'(req_q.size() < DEPTH));
    if (bus.out_valid) begin
      chk("out_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        chk("out_func", 32'(bus.out_func), 32'(exp_q[0].f));
        chk("out_ipart", 32'(bus.out_ipart), 32'(exp_q[0].ip));
        chk("out_fpart", 32'(bus.out_fpart), 32'(exp_q[0].fp));
      end
    end
    bus.in_valid  = d_valid;
    bus.in_func   = d_func;
    bus.in_x      = d_x;
    bus.out_ready = d_ordy;
    last_acc = d_valid && bus.in_ready;
    if (last_acc) req_q.push_back(req_s'{d_func, d_x});
    if (bus.out_valid && d_ordy && exp_q.size() != 0) begin
      exp_q.delete(0);
      n_res++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    d_valid = 1'b0; d_ordy = 1'b0;
    tick(); tick();
    rst = 1'b0;
    req_q.delete(); exp_q.delete();
    n_res = 0; r_never = 1'b0; r_rand = 1'b0;
    #1;
  endtask

  task automatic drain(input int maxc);
    bit done;
    done = 1'b0;
    d_valid = 1'b0; d_ordy = 1'b1;
    for (int i = 0; i < maxc && !done; i++) begin
      step();
      done = (req_q.size() == 0) && (exp_q.size() == 0) && !bus.busy && !bus.out_valid &&
             (dly_c == 0) && (len_c == 0);
    end
    chk("drain_done", 32'(done), 1);
  endtask

  typedef struct {
    logic [1:0] f; logic [7:0] x; int dly; int len; logic [7:0] ip; logic [7:0] fp;
    bit never; bit e_valid; bit e_err; int e_lat;
  } vec_s;
  vec_s tbl[6];

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s0, lat, viol, pushed, guard, n_push, k, n;
    logic [7:0] snap_ip, snap_fp;
    logic [1:0] snap_f;

    bus.in_valid = 1'b0; bus.in_func = 2'd0; bus.in_x = 8'h0; bus.busy = 1'b0;
    bus.resultIPart = 8'h0; bus.resultFPart = 8'h0; bus.out_ready = 1'b0;

    // latency = push edge to out_valid (2 + dly + len) or to err (2 + TMO)
    tbl[0] = '{2'd0, 8'h5A, 2,  6, 8'h03, 8'h80, 1'b0, 1'b1, 1'b0, 10};
    tbl[1] = '{2'd3, 8'hFF, 1,  1, 8'hFF, 8'h01, 1'b0, 1'b1, 1'b0, 4};
    tbl[2] = '{2'd1, 8'h00, 14, 2, 8'hAA, 8'h55, 1'b0, 1'b1, 1'b0, 18};
    tbl[3] = '{2'd2, 8'hC3, 15, 3, 8'h11, 8'h22, 1'b0, 1'b0, 1'b1, 17};
    tbl[4] = '{2'd2, 8'h7E, 2,  2, 8'h33, 8'h44, 1'b1, 1'b0, 1'b1, 17};
    tbl[5] = '{2'd1, 8'h81, 3,  9, 8'h00, 8'hFF, 1'b0, 1'b1, 1'b0, 14};

    // reset state
    tick(); tick();
    chk("rst_in_ready", 32'(bus.in_ready), 0);
    chk("rst_start", 32'(bus.start), 0);
    chk("rst_func", 32'(bus.func), 0);
    chk("rst_x", 32'(bus.x), 0);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_out_func", 32'(bus.out_func), 0);
    chk("rst_out_ipart", 32'(bus.out_ipart), 0);
    chk("rst_out_fpart", 32'(bus.out_fpart), 0);
    chk("rst_err", 32'(bus.err_timeout), 0);
    rst = 1'b0; #1;
    chk("rel_in_ready", 32'(bus.in_ready), 1);

    // vector table: one request each, exact latency and outcome
    for (int i = 0; i < 6; i++) begin
      do_reset();
      r_dly = tbl[i].dly; r_len = tbl[i].len; r_ip = tbl[i].ip; r_fp = tbl[i].fp;
      r_never = tbl[i].never;
      s0 = n_starts;
      chk("v_in_ready", 32'(bus.in_ready), 1);
      bus.in_valid = 1'b1; bus.in_func = tbl[i].f; bus.in_x = tbl[i].x;
      tick();
      bus.in_valid = 1'b0;
      lat = 0;
      while (!bus.out_valid && !bus.err_timeout && lat < 40) begin
        if (bus.busy) chk("v_x_hold", 32'(bus.x), 32'(tbl[i].x));
        tick(); lat++;
      end
      chk("v_latency", 32'(lat), 32'(tbl[i].e_lat));
      chk("v_out_valid", 32'(bus.out_valid), 32'(tbl[i].e_valid));
      chk("v_err", 32'(bus.err_timeout), 32'(tbl[i].e_err));
      if (tbl[i].e_valid) begin
        chk("v_out_func", 32'(bus.out_func), 32'(tbl[i].f));
        chk("v_out_ipart", 32'(bus.out_ipart), 32'(tbl[i].ip));
        chk("v_out_fpart", 32'(bus.out_fpart), 32'(tbl[i].fp));
      end
      bus.out_ready = 1'b1; tick(); bus.out_ready = 1'b0;
      viol = 0;
      for (int j = 0; j < 12; j++) begin
        tick();
        if (bus.out_valid || bus.start) viol++;
      end
      chk("v_quiet_after", 32'(viol), 0);
      chk("v_one_start", 32'(n_starts - s0), 1);
    end

    // FIFO fill: five back-to-back pushes while the first op runs
    do_reset();
    r_rand = 1'b1;
    pushed = 0; guard = 0; d_ordy = 1'b1;
    while (pushed < 5 && guard < 20) begin
      d_valid = 1'b1; d_func = pushed[1:0]; d_x = 8'(8'h10 + pushed);
      step();
      if (last_acc) pushed++;
      guard++;
    end
    chk("fill_back_to_back", 32'(guard), 5);
    d_valid = 1'b0;
    step();
    chk("fill_full_in_ready", 32'(bus.in_ready), 0);
    drain(300);
    chk("fill_results", 32'(n_res), 5);

    // output backpressure: result held 10 cycles, no start, resume after ready
    do_reset();
    r_rand = 1'b1;
    d_valid = 1'b1; d_func = 2'd1; d_x = 8'h21; step();
    d_func = 2'd2; d_x = 8'h42; step();
    d_valid = 1'b0; d_ordy = 1'b0;
    guard = 0;
    while (!bus.out_valid && guard < 40) begin step(); guard++; end
    chk("bp_out_valid_seen", 32'(bus.out_valid), 1);
    snap_f = bus.out_func; snap_ip = bus.out_ipart; snap_fp = bus.out_fpart;
    for (int j = 0; j < 10; j++) begin
      step();
      chk("bp_no_start", 32'(bus.start), 0);
      chk("bp_valid_held", 32'(bus.out_valid), 1);
      chk("bp_stable", {22'd0, bus.out_func, bus.out_ipart}, {22'd0, snap_f, snap_ip});
      chk("bp_stable_fp", 32'(bus.out_fpart), 32'(snap_fp));
    end
    d_ordy = 1'b1; step();
    d_ordy = 1'b0; step();
    chk("bp_no_start_idle", 32'(bus.start), 0);
    step();
    chk("bp_resume_start", 32'(bus.start), 1);
    drain(100);
    chk("bp_results", 32'(n_res), 2);

    // timeout, then the next queued request runs normally
    do_reset();
    r_dly = 2; r_len = 3; r_ip = 8'h5C; r_fp = 8'hC5; r_never = 1'b1;
    d_valid = 1'b1; d_func = 2'd3; d_x = 8'h99; step();
    d_func = 2'd1; d_x = 8'h66; step();
    d_valid = 1'b0;
    guard = 0;
    while (n_starts == 0 || !bus.start) begin
      if (guard > 10) break;
      step(); guard++;
    end
    chk("tmo_first_start", 32'(bus.start), 1);
    r_never = 1'b0;
    k = 0;
    while (!bus.err_timeout && k < 40) begin step(); k++; end
    chk("tmo_latency", 32'(k), 32'(TMO + 1));
    chk("tmo_err_set", 32'(bus.err_timeout), 1);
    drain(80);
    chk("tmo_next_result", 32'(n_res), 1);
    chk("tmo_err_sticky", 32'(bus.err_timeout), 1);

    // asynchronous reset while busy with two requests queued
    do_reset();
    r_dly = 1; r_len = 20; r_ip = 8'hA5; r_fp = 8'h5A;
    d_valid = 1'b1; d_func = 2'd3; d_x = 8'hE7; step();
    d_func = 2'd2; d_x = 8'h0F; step();
    d_func = 2'd1; d_x = 8'hF0; step();
    d_valid = 1'b0;
    guard = 0;
    while (!bus.busy && guard < 20) begin step(); guard++; end
    chk("rr_busy_seen", 32'(bus.busy), 1);
    chk("rr_func_before", 32'(bus.func), 3);
    #3 rst = 1'b1;
    #1;
    chk("rr_start", 32'(bus.start), 0);
    chk("rr_func", 32'(bus.func), 0);
    chk("rr_x", 32'(bus.x), 0);
    chk("rr_out_valid", 32'(bus.out_valid), 0);
    chk("rr_out_all", {8'd0, 6'd0, bus.out_func, bus.out_ipart, bus.out_fpart}, 0);
    chk("rr_err", 32'(bus.err_timeout), 0);
    chk("rr_in_ready", 32'(bus.in_ready), 0);
    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    tick();
    rst = 1'b0;
    req_q.delete(); exp_q.delete(); n_res = 0;
    s0 = n_starts;
    for (int j = 0; j < 20; j++) step();
    chk("rr_no_restart", 32'(n_starts - s0), 0);
    d_valid = 1'b1; d_func = 2'd2; d_x = 8'h3C; step();
    drain(60);
    chk("rr_new_push_runs", 32'(n_res), 1);

    // push in the same cycle the FSM pops the single queued entry
    do_reset();
    r_dly = 1; r_len = 2; r_ip = 8'h12; r_fp = 8'h34;
    d_valid = 1'b1; d_func = 2'd0; d_x = 8'hA0; step();
    d_func = 2'd1; d_x = 8'hB1; step();
    d_valid = 1'b0; d_ordy = 1'b0;
    guard = 0;
    while (!bus.out_valid && guard < 30) begin step(); guard++; end
    chk("pp_first_result", 32'(bus.out_valid), 1);
    d_ordy = 1'b1; step();
    d_ordy = 1'b0; d_valid = 1'b1; d_func = 2'd2; d_x = 8'hC2; step();
    chk("pp_push_on_pop", 32'(last_acc), 1);
    d_valid = 1'b0; step();
    chk("pp_popped_start", 32'(bus.start), 1);
    n = 0;
    d_valid = 1'b1; d_func = 2'd3; d_x = 8'hD3;
    for (int j = 0; j < 6; j++) begin
      step();
      if (last_acc) n++;
    end
    chk("pp_room_left", 32'(n), 3);
    drain(200);
    chk("pp_results", 32'(n_res), 6);

    // randomized traffic against the queue model
    do_reset();
    r_rand = 1'b1;
    n_push = 0;
    for (int j = 0; j < 600; j++) begin
      d_valid = ($urandom_range(0, 9) < 6);
      d_func  = 2'($urandom);
      d_x     = 8'($urandom);
      d_ordy  = ($urandom_range(0, 3) != 0);
      step();
      if (last_acc) n_push++;
    end
    drain(400);
    chk("rand_all_results", 32'(n_res), 32'(n_push));
    chk("rand_no_err", 32'(bus.err_timeout), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
